// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer owning the PC, driving instruction memory via req/ack and decode via valid/ready
//   clk, res                       clock, synchronous active-high reset
//   br_valid, br_target            branch redirect request and target PC
//   imem_req, imem_addr            fetch request and address to instruction memory
//   imem_ack, imem_data            memory completion and returned instruction word
//   instr_valid, instr, instr_pc   fetched instruction presented to decode
//   instr_ready                    decode accepts the presented instruction
module fetch_ctrl #(
    parameter int DBITS = 32,
    parameter logic [DBITS-1:0] START_PC = 32'h40,
    parameter logic [DBITS-1:0] PC_STEP = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             br_valid,
    input  logic [DBITS-1:0] br_target,
    output logic             imem_req,
    output logic [DBITS-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [DBITS-1:0] imem_data,
    output logic             instr_valid,
    output logic [DBITS-1:0] instr,
    output logic [DBITS-1:0] instr_pc,
    input  logic             instr_ready
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
    state_t state_q, state_d;
    logic [DBITS-1:0] pc_q, pc_d, redir_q, redir_d, instr_q, instr_d, instr_pc_q, instr_pc_d, imem_addr_q;
    logic squash_q, squash_d, instr_valid_q, instr_valid_d, imem_req_q;

    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        redir_d = redir_q;
        squash_d = squash_q;
        instr_d = instr_q;
        instr_pc_d = instr_pc_q;
        instr_valid_d = instr_valid_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (br_valid) pc_d = br_target;
            end
            REQ: begin
                if (imem_ack) begin
                    // a redirect seen now or earlier in this fetch discards the returned word
                    squash_d = 1'b0;
                    if (br_valid) pc_d = br_target;
                    else if (squash_q) pc_d = redir_q;
                    else begin
                        instr_d = imem_data;
                        instr_pc_d = pc_q;
                        instr_valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end else if (br_valid) begin
                    redir_d = br_target;
                    squash_d = 1'b1;
                end
            end
            HOLD: begin
                // a branch in the accept cycle came from this instruction, so its target wins
                if (br_valid || instr_ready) begin
                    pc_d = br_valid ? br_target : instr_pc_q + PC_STEP;
                    instr_valid_d = 1'b0;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= IDLE;
            pc_q <= START_PC;
            redir_q <= '0;
            squash_q <= 1'b0;
            instr_q <= '0;
            instr_pc_q <= '0;
            instr_valid_q <= 1'b0;
            imem_req_q <= 1'b0;
            imem_addr_q <= START_PC;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            redir_q <= redir_d;
            squash_q <= squash_d;
            instr_q <= instr_d;
            instr_pc_q <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q <= state_d == REQ;
            imem_addr_q <= pc_d;
        end
    end

    assign imem_req = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr = instr_q;
    assign instr_pc = instr_pc_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized checks of fetch_ctrl against a fetch-stream reference model
module tb_fetch_ctrl;
    logic clk = 1'b0, res = 1'b1, br_valid = 1'b0, imem_ack = 1'b0, instr_ready = 1'b0;
    logic [31:0] br_target = '0, imem_data = '0;
    logic imem_req, instr_valid;
    logic [31:0] imem_addr, instr, instr_pc;
    int checks = 0, passes = 0;
    bit m_idle = 1'b1, m_fetch = 1'b0, m_hold = 1'b0;
    logic [31:0] m_pc = 32'h40;
    logic [31:0] redq[$];

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk(clk), .res(res), .br_valid(br_valid), .br_target(br_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0DEF00D;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // the model tracks only: phase, the PC being fetched or held, and redirects pending on the current fetch
    task automatic compare_all();
        check("imem_req", 32'(imem_req), 32'(m_fetch));
        check("instr_valid", 32'(instr_valid), 32'(m_hold));
        if (m_fetch) check("imem_addr", imem_addr, m_pc);
        if (m_hold) begin
            check("instr_pc", instr_pc, m_pc);
            check("instr", instr, mem_word(m_pc));
        end
    endtask

    task automatic cyc(input bit r, input bit b, input logic [31:0] t, input bit a, input bit y);
        @(negedge clk);
        compare_all();
        res = r;
        br_valid = b;
        br_target = t;
        imem_ack = a;
        instr_ready = y;
        imem_data = a ? mem_word(imem_addr) : $urandom;
        @(posedge clk);
        if (r) begin
            m_idle = 1'b1; m_fetch = 1'b0; m_hold = 1'b0; m_pc = 32'h40;
            redq.delete();
        end else if (m_idle) begin
            if (b) m_pc = t;
            m_idle = 1'b0; m_fetch = 1'b1;
        end else if (m_fetch) begin
            if (a) begin
                if (b) m_pc = t;
                else if (redq.size() > 0) m_pc = redq[$];
                else begin m_fetch = 1'b0; m_hold = 1'b1; end
                redq.delete();
            end else if (b) redq.push_back(t);
        end else if (b || y) begin
            m_pc = b ? t : m_pc + 32'd4;
            m_hold = 1'b0; m_fetch = 1'b1;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_addr", imem_addr, 32'h40);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        cyc(0, 0, 0, 0, 0);
        #1 check("t1_first_req", 32'(imem_req), 32'd1);
        for (int k = 0; k < 3; k++) begin
            #1 check("t1_addr", imem_addr, 32'(32'h40 + 4 * k));
            cyc(0, 0, 0, 1, 1);
            #1 check("t1_pc", instr_pc, 32'(32'h40 + 4 * k));
            cyc(0, 0, 0, 0, 1);
        end
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            #1 check("t2_req_held", 32'(imem_req), 32'd1);
            check("t2_addr_held", imem_addr, 32'h40);
            cyc(0, 0, 0, 0, 1);
        end
        cyc(0, 0, 0, 1, 0);
        #1 check("t2_valid", 32'(instr_valid), 32'd1);
        check("t2_instr", instr, mem_word(32'h40));
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 0);
            #1 check("t3_pc_stable", instr_pc, 32'h40);
            check("t3_no_req", 32'(imem_req), 32'd0);
        end
        cyc(0, 0, 0, 0, 1);
        #1 check("t3_next_addr", imem_addr, 32'h44);
        cyc(0, 1, 32'h100, 0, 0);
        cyc(0, 1, 32'h200, 0, 0);
        cyc(0, 0, 0, 1, 0);
        #1 check("t4_dropped", 32'(instr_valid), 32'd0);
        check("t4_addr", imem_addr, 32'h200);
        cyc(0, 0, 0, 1, 0);
        #1 check("t4_pc", instr_pc, 32'h200);
        cyc(0, 1, 32'h80, 0, 1);
        #1 check("t5_addr", imem_addr, 32'h80);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        #1 check("t6_rst_req", 32'(imem_req), 32'd0);
        check("t6_rst_addr", imem_addr, 32'h40);
        check("t6_rst_valid", 32'(instr_valid), 32'd0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 32'hFFFFFFFC, 0, 0);
        cyc(0, 0, 0, 1, 0);
        #1 check("t6_redir", imem_addr, 32'hFFFFFFFC);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        #1 check("t6_wrap", imem_addr, 32'h0);
        for (int i = 0; i < 4000; i++)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, $urandom & 32'hFFFFFFFC,
                $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
        cyc(0, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
